// File: rtl/pmem_pkg.sv
// Shared types and address helpers for the banked physical-memory model.
package pmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } pmem_state_e;

  // Byte-offset bits inside one line: log2(LINE_WIDTH/8).
  function automatic int unsigned offset_bits(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

  // Line index: drop the byte offset, keep idx_bits of the remaining address.
  function automatic int unsigned line_index(input logic [63:0] addr,
                                             input int unsigned off_bits,
                                             input int unsigned idx_bits);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = addr >> off_bits;
    mask    = (64'(1) << idx_bits) - 64'(1);
    return 32'(shifted & mask);
  endfunction

  // Row number of a line: line index divided by lines-per-row.
  function automatic int unsigned row_of(input int unsigned line,
                                         input int unsigned row_shift);
    return line >> row_shift;
  endfunction

endpackage

// File: rtl/pmem_row_tracker.sv
// Open-row buffer: remembers the most recently opened row and flags hits.
module pmem_row_tracker
  import pmem_pkg::*;
#(
  parameter int unsigned ROW_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ROW_W-1:0] row,
  output logic             hit_c
);

  logic [ROW_W-1:0] open_row;
  logic             open_valid;

  // Open the requested row on every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_row   <= '0;
      open_valid <= 1'b0;
    end else if (load) begin
      open_row   <= row;
      open_valid <= 1'b1;
    end
  end

  assign hit_c = open_valid && (row == open_row);

endmodule

// File: rtl/pmem_banked_model.sv
// Cycle-accurate line memory with an open-row buffer and hit/miss latency.
module pmem_banked_model
  import pmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned ROW_LINES  = 8,
  parameter int unsigned HIT_LAT    = 2,
  parameter int unsigned MISS_LAT   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [LINE_WIDTH-1:0] wdata,
  output logic                  resp,
  output logic [LINE_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  row_hit
);

  localparam int unsigned OFF_W     = offset_bits(LINE_WIDTH);
  localparam int unsigned IDX_W     = ADDR_WIDTH - OFF_W;
  localparam int unsigned ROW_SH    = $clog2(ROW_LINES);
  localparam int unsigned ROW_W     = IDX_W - ROW_SH;
  localparam int unsigned NUM_LINES = 1 << IDX_W;
  localparam int unsigned CNT_W     = $clog2(MISS_LAT + 1);

  pmem_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             op_write;
  logic [IDX_W-1:0] line_q;

  logic [IDX_W-1:0] idx_c;
  logic [ROW_W-1:0] row_c;
  logic             hit_c;
  logic             accept_c;
  logic             commit_c;

  logic [LINE_WIDTH-1:0] mem [NUM_LINES];

  assign idx_c    = IDX_W'(line_index(64'(address), OFF_W, IDX_W));
  assign row_c    = ROW_W'(row_of(32'(idx_c), ROW_SH));
  assign accept_c = (state == ST_IDLE) && (read ^ write);
  assign commit_c = (state == ST_BUSY) && (cnt == '0) && op_write;

  pmem_row_tracker #(
    .ROW_W (ROW_W)
  ) u_row_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_c),
    .row   (row_c),
    .hit_c (hit_c)
  );

  // Request FSM: accept, count down the access latency, then pulse resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      line_q   <= '0;
      resp     <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
      row_hit  <= 1'b0;
    end else begin
      resp <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read && write) begin
            err <= 1'b1;
          end else if (read || write) begin
            op_write <= write;
            line_q   <= idx_c;
            row_hit  <= hit_c;
            cnt      <= hit_c ? CNT_W'(HIT_LAT - 1) : CNT_W'(MISS_LAT - 1);
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            if (!read && !write) begin
              state <= ST_IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end else begin
            state <= ST_RESP;
            resp  <= 1'b1;
            if (!op_write) begin
              rdata <= mem[line_q];
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage array; contents survive reset, writes land at commit.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      mem[line_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_pmem_banked_model.sv
// Randomised scoreboard bench for pmem_banked_model against a line/row model.
module tb_pmem_banked_model;

  logic         clk;
  logic         rst_n;
  logic         read;
  logic         write;
  logic [15:0]  address;
  logic [127:0] wdata;
  logic         resp;
  logic [127:0] rdata;
  logic         err;
  logic         row_hit;

  pmem_banked_model #(
    .ADDR_WIDTH (16),
    .LINE_WIDTH (128),
    .ROW_LINES  (8),
    .HIT_LAT    (2),
    .MISS_LAT   (6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .read    (read),
    .write   (write),
    .address (address),
    .wdata   (wdata),
    .resp    (resp),
    .rdata   (rdata),
    .err     (err),
    .row_hit (row_hit)
  );

  typedef struct {
    bit           is_rd;
    logic [127:0] data;
    bit           hit;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model_mem[int];
  int           open_row;
  bit           open_valid;

  int n_cmp;
  int n_fail;
  int cyc;
  int exp_resp;
  int got_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] model_read(input int line);
    if (model_mem.exists(line)) return model_mem[line];
    return '0;
  endfunction

  // Monitor: every resp pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp) begin
      got_resp++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 128'(1), 128'(0));
      end else begin
        e = sb.pop_front();
        if (e.is_rd) chk("rdata", rdata, e.data);
        chk("row_hit", 128'(row_hit), 128'(e.hit));
        chk("resp_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // One request; abort_after>0 drops the request after that many BUSY cycles.
  task automatic do_req(input bit is_wr, input logic [15:0] addr, input logic [127:0] d,
                        input int abort_after, input bit scramble);
    int           line;
    int           row;
    bit           hit;
    int           lat;
    int           waited;
    logic [127:0] d_final;
    exp_t         e;
    line    = int'(addr) / 16;
    row     = line / 8;
    hit     = open_valid && (row == open_row);
    lat     = hit ? 2 : 6;
    open_row   = row;
    open_valid = 1'b1;
    d_final = scramble ? {$urandom, $urandom, $urandom, $urandom} : d;
    read    = !is_wr;
    write   = is_wr;
    address = addr;
    wdata   = d;
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      read  = 1'b0;
      write = 1'b0;
      repeat (8) @(negedge clk);
      return;
    end
    e.is_rd = !is_wr;
    e.data  = is_wr ? '0 : model_read(line);
    e.hit   = hit;
    e.cyc   = cyc + 1 + lat;
    sb.push_back(e);
    exp_resp++;
    @(negedge clk);
    if (scramble) begin
      address = 16'($urandom);
      wdata   = d_final;
    end
    waited = 0;
    while (!resp && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!resp) chk("resp_timeout", 128'(0), 128'(1));
    read  = 1'b0;
    write = 1'b0;
    if (is_wr) model_mem[line] = d_final;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] pat_a5;
    logic [127:0] pat_12;
    n_cmp = 0; n_fail = 0; cyc = 0; exp_resp = 0; got_resp = 0;
    open_row = 0; open_valid = 1'b0;
    pat_a5 = {16{8'hA5}};
    pat_12 = {8{16'h1234}};
    rst_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp", 128'(resp), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_row_hit", 128'(row_hit), 128'(0));
    chk("rst_rdata", rdata, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Miss then hit on the same line; offset bits ignored; row 1 miss.
    do_req(1'b1, 16'h0010, pat_a5, 0, 1'b0);
    do_req(1'b0, 16'h0010, '0, 0, 1'b0);
    do_req(1'b0, 16'h0018, '0, 0, 1'b0);
    do_req(1'b0, 16'h0080, '0, 0, 1'b0);

    // Conflicting requests in IDLE.
    read = 1'b1; write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_high", 128'(err), 128'(1));
    end
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("err_low", 128'(err), 128'(0));

    // Aborted write: row opens, array untouched.
    do_req(1'b1, 16'h0200, pat_12, 3, 1'b0);
    do_req(1'b0, 16'h0200, '0, 0, 1'b0);

    // Reset during BUSY of a write.
    read = 1'b0; write = 1'b1; address = 16'h0300; wdata = pat_12;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_resp", 128'(resp), 128'(0));
    chk("midrst_err", 128'(err), 128'(0));
    chk("midrst_row_hit", 128'(row_hit), 128'(0));
    chk("midrst_rdata", rdata, 128'(0));
    write = 1'b0;
    open_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 16'h0300, '0, 0, 1'b0);

    // Back-to-back requests to row 0.
    do_req(1'b0, 16'h0000, '0, 0, 1'b0);
    do_req(1'b0, 16'h0010, '0, 0, 1'b0);
    do_req(1'b0, 16'h0020, '0, 0, 1'b0);

    // Random traffic over a few rows, with address/wdata changes mid-flight.
    for (int i = 0; i < 200; i++) begin
      do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'h03FF)),
             {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("resp_count", 128'(got_resp), 128'(exp_resp));
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
